elevator_car_model: RTL and testbench
=====================================

// Module: elevator_car_model
// PURPOSE
//  Synthesizable plant model of the car, shaft and door actuator: the far end of the elevator
//  controller's engine/door command interface. Consumes engine and door commands and produces
//  car position, floor-arrival pulses, door status and fault flags. Closes the loop in benches
//  and FPGA demos, replacing hand-timed sensor stimulus.
// PARAMETERS
//  FLOORS         8  number of floors, numbered 0..FLOORS-1
//  FLOOR_W        3  floor index width, $clog2(FLOORS)
//  TRAVEL_CYCLES  4  clock cycles to move one floor, >=2
//  DOOR_CYCLES    3  clock cycles for a full door open or close stroke, >=1
// PORTS
//  clk           in   1        system clock
//  reset         in   1        asynchronous reset, active-high
//  engine        in   2        00 stop, 01 up, 10 down, 11 illegal
//  door          in   2        00 hold, 01 open, 10 close, 11 hold
//  obstruct      in   1        light-curtain input; blocks or reverses closing
//  floor         out  FLOOR_W  current floor register
//  at_floor      out  1        car level with floor (offset == 0)
//  floor_arrive  out  1        1-cycle pulse when car becomes level at a floor
//  limit_hit     out  1        1-cycle pulse: move request at shaft end, ignored
//  door_state    out  2        00 CLOSED, 01 OPENING, 10 OPEN, 11 CLOSING
//  door_closed   out  1        door_state == CLOSED
//  door_open     out  1        door_state == OPEN
//  fault         out  1        sticky safety violation; cleared only by reset
// BEHAVIOUR
//  Reset (async): floor=0, off=0, door CLOSED, at_floor=1, door_closed=1, all other outputs 0.
//  Position: floor reg plus offset counter off, range 0..TRAVEL_CYCLES-1. Outputs are registered.
//  Motion is enabled only if door_closed=1. Evaluate each cycle:
//   UP:   if floor==FLOORS-1 && off==0, no move and limit_hit=1.
//         Else if off==TRAVEL_CYCLES-1, floor++, off=0, floor_arrive=1. Else off++.
//   DOWN: if floor==0 && off==0, no move and limit_hit=1.
//         Else if off==0, floor--, off=TRAVEL_CYCLES-1.
//         Else off--; floor_arrive=1 when off goes 1->0.
//   Result: one floor takes exactly TRAVEL_CYCLES cycles in either direction. While descending,
//   floor shows the lower floor.
//   STOP mid-span holds off; a reversal mid-span counts off back with no arrive until level.
//  Faults (set fault=1, no motion that cycle): engine=11; engine UP/DOWN while door not CLOSED.
//  Door FSM, stroke counter dcnt:
//   CLOSED --open cmd & at_floor & engine==00--> OPENING (dcnt=DOOR_CYCLES)
//     open cmd with at_floor=0 or engine!=00: ignored, fault=1
//   OPENING: dcnt--; at 1 -> OPEN. Close cmd ignored.
//   OPEN --close cmd & !obstruct--> CLOSING (dcnt=DOOR_CYCLES); with obstruct: stay OPEN
//   CLOSING: dcnt--; at 1 -> CLOSED. Obstruct or open cmd -> OPENING with dcnt reloaded.
//  Simultaneous: the door FSM and motion use the same-cycle state. Engine UP in the cycle the door
//   reaches CLOSED does not move; motion starts the next cycle.
//  Reset mid-travel or mid-stroke returns to reset values immediately, with no arrive pulse.
// STRUCTURE
//  elevator_pkg: engine/door command encodings, door_state encodings, shared with the controller.
//  Sub-module elevator_door_actuator: door FSM plus dcnt. Top holds position logic and fault.
// TESTING (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
//  1 reset pulse -> floor=0, at_floor=1, door_closed=1, fault=0, limit_hit=0
//  2 engine=01 held 30 cycles -> floor_arrive every 4 cycles, floor=7 at cycle 28,
//    then limit_hit each cycle, fault=0
//  3 at floor 7, engine=00, door=01 one cycle -> door_state 01, door_open=1 3 cycles later;
//    then engine=01 -> no motion, fault=1
//  4 door OPEN, door=10, obstruct=1 at 2nd CLOSING cycle -> OPENING, OPEN 3 cycles later;
//    obstruct=0 and close again -> CLOSED after 3 cycles
//  5 from floor 3, engine=10 -> floor=2 next cycle, at_floor=0, floor_arrive 4 cycles after start;
//    reversal to 01 after 2 cycles -> floor=3, no arrive until level
//  6 reset asserted mid-span (off=2) -> floor=0, at_floor=1, no floor_arrive, door CLOSED

Source files
------------

// File: rtl/elevator_pkg.sv
// Command and status encodings shared between the elevator controller and the car plant model.
package elevator_pkg;

  typedef enum logic [1:0] {
    ENG_STOP    = 2'b00,
    ENG_UP      = 2'b01,
    ENG_DOWN    = 2'b10,
    ENG_ILLEGAL = 2'b11
  } engine_cmd_e;

  typedef enum logic [1:0] {
    DOOR_HOLD      = 2'b00,
    DOOR_OPEN_CMD  = 2'b01,
    DOOR_CLOSE_CMD = 2'b10,
    DOOR_HOLD_ALT  = 2'b11
  } door_cmd_e;

  typedef enum logic [1:0] {
    DS_CLOSED  = 2'b00,
    DS_OPENING = 2'b01,
    DS_OPEN    = 2'b10,
    DS_CLOSING = 2'b11
  } door_state_e;

endpackage

// File: rtl/elevator_door_actuator.sv
// Door actuator: open/close stroke FSM with a stroke counter and light-curtain reversal.
module elevator_door_actuator
  import elevator_pkg::*;
#(
  parameter int DOOR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] door,
  input  logic       obstruct,
  input  logic       open_ok,
  output logic [1:0] door_state,
  output logic       door_closed,
  output logic       door_open
);

  localparam int DW = (DOOR_CYCLES < 2) ? 1 : $clog2(DOOR_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LOAD = DW'(DOOR_CYCLES);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);

  door_state_e     state_r;
  logic [DW-1:0]   dcnt_r;
  door_cmd_e       cmd_s;

  assign cmd_s      = door_cmd_e'(door);
  assign door_state = state_r;

  // Door stroke FSM; status flags are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= DS_CLOSED;
      dcnt_r      <= '0;
      door_closed <= 1'b1;
      door_open   <= 1'b0;
    end else begin
      case (state_r)
        DS_CLOSED: begin
          if (cmd_s == DOOR_OPEN_CMD && open_ok) begin
            state_r     <= DS_OPENING;
            dcnt_r      <= DCNT_LOAD;
            door_closed <= 1'b0;
          end
        end
        DS_OPENING: begin
          if (dcnt_r == DCNT_ONE) begin
            state_r   <= DS_OPEN;
            dcnt_r    <= '0;
            door_open <= 1'b1;
          end else begin
            dcnt_r <= dcnt_r - DCNT_ONE;
          end
        end
        DS_OPEN: begin
          if (cmd_s == DOOR_CLOSE_CMD && !obstruct) begin
            state_r   <= DS_CLOSING;
            dcnt_r    <= DCNT_LOAD;
            door_open <= 1'b0;
          end
        end
        DS_CLOSING: begin
          // Light curtain or a fresh open request reverses the stroke from full length.
          if (obstruct || cmd_s == DOOR_OPEN_CMD) begin
            state_r <= DS_OPENING;
            dcnt_r  <= DCNT_LOAD;
          end else if (dcnt_r == DCNT_ONE) begin
            state_r     <= DS_CLOSED;
            dcnt_r      <= '0;
            door_closed <= 1'b1;
          end else begin
            dcnt_r <= dcnt_r - DCNT_ONE;
          end
        end
        default: begin
          state_r     <= DS_CLOSED;
          dcnt_r      <= '0;
          door_closed <= 1'b1;
          door_open   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/elevator_car_model.sv
// Plant model of car, shaft and door: turns engine/door commands into position,
// arrival pulses, door status and a sticky safety fault.
module elevator_car_model
  import elevator_pkg::*;
#(
  parameter int FLOORS        = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         engine,
  input  logic [1:0]         door,
  input  logic               obstruct,
  output logic [FLOOR_W-1:0] floor,
  output logic               at_floor,
  output logic               floor_arrive,
  output logic               limit_hit,
  output logic [1:0]         door_state,
  output logic               door_closed,
  output logic               door_open,
  output logic               fault
);

  localparam int OFF_W = $clog2(TRAVEL_CYCLES);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);
  localparam logic [OFF_W-1:0]   OFF_MAX   = OFF_W'(TRAVEL_CYCLES - 1);
  localparam logic [OFF_W-1:0]   OFF_ONE   = OFF_W'(1);

  engine_cmd_e        eng_s;
  logic [OFF_W-1:0]   off_r;
  logic [FLOOR_W-1:0] floor_n_s;
  logic [OFF_W-1:0]   off_n_s;
  logic               arrive_n_s;
  logic               limit_n_s;
  logic               move_req_s;
  logic               door_fault_s;
  logic               open_reject_s;
  logic               open_ok_s;

  assign eng_s         = engine_cmd_e'(engine);
  assign move_req_s    = (eng_s == ENG_UP) || (eng_s == ENG_DOWN);
  assign door_fault_s  = move_req_s && !door_closed;
  assign open_ok_s     = at_floor && (eng_s == ENG_STOP);
  assign open_reject_s = door_closed && (door_cmd_e'(door) == DOOR_OPEN_CMD) && !open_ok_s;

  elevator_door_actuator #(
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_door (
    .clk        (clk),
    .reset      (reset),
    .door       (door),
    .obstruct   (obstruct),
    .open_ok    (open_ok_s),
    .door_state (door_state),
    .door_closed(door_closed),
    .door_open  (door_open)
  );

  // Next position; descending shows the lower floor with off counting down to it.
  always_comb begin
    floor_n_s  = floor;
    off_n_s    = off_r;
    arrive_n_s = 1'b0;
    limit_n_s  = 1'b0;
    if (door_closed) begin
      case (eng_s)
        ENG_UP: begin
          if (floor == TOP_FLOOR && off_r == '0) begin
            limit_n_s = 1'b1;
          end else if (off_r == OFF_MAX) begin
            floor_n_s  = floor + FLOOR_ONE;
            off_n_s    = '0;
            arrive_n_s = 1'b1;
          end else begin
            off_n_s = off_r + OFF_ONE;
          end
        end
        ENG_DOWN: begin
          if (floor == '0 && off_r == '0) begin
            limit_n_s = 1'b1;
          end else if (off_r == '0) begin
            floor_n_s = floor - FLOOR_ONE;
            off_n_s   = OFF_MAX;
          end else begin
            off_n_s    = off_r - OFF_ONE;
            arrive_n_s = (off_r == OFF_ONE);
          end
        end
        default: begin
          floor_n_s = floor;
          off_n_s   = off_r;
        end
      endcase
    end else begin
      floor_n_s = floor;
      off_n_s   = off_r;
    end
  end

  // Position, pulse outputs and sticky fault register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      floor        <= '0;
      off_r        <= '0;
      at_floor     <= 1'b1;
      floor_arrive <= 1'b0;
      limit_hit    <= 1'b0;
      fault        <= 1'b0;
    end else begin
      floor        <= floor_n_s;
      off_r        <= off_n_s;
      at_floor     <= (off_n_s == '0);
      floor_arrive <= arrive_n_s;
      limit_hit    <= limit_n_s;
      fault        <= fault | (eng_s == ENG_ILLEGAL) | door_fault_s | open_reject_s;
    end
  end

endmodule

// File: tb/tb_elevator_car_model.sv
// Directed bench for elevator_car_model with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
module tb_elevator_car_model;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] engine;
  logic [1:0] door;
  logic       obstruct;
  logic [2:0] floor;
  logic       at_floor;
  logic       floor_arrive;
  logic       limit_hit;
  logic [1:0] door_state;
  logic       door_closed;
  logic       door_open;
  logic       fault;

  int vectors = 0;
  int miscompares = 0;

  elevator_car_model #(
    .FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .engine      (engine),
    .door        (door),
    .obstruct    (obstruct),
    .floor       (floor),
    .at_floor    (at_floor),
    .floor_arrive(floor_arrive),
    .limit_hit   (limit_hit),
    .door_state  (door_state),
    .door_closed (door_closed),
    .door_open   (door_open),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; engine = 2'b00; door = 2'b00; obstruct = 1'b0;
    #2;
    chk("rst_floor", 32'(floor), 32'd0);
    chk("rst_at_floor", 32'(at_floor), 32'd1);
    chk("rst_door_closed", 32'(door_closed), 32'd1);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_limit", 32'(limit_hit), 32'd0);
    step();
    reset = 1'b0;

    // Climb the whole shaft, then hold UP against the top limit.
    engine = 2'b01;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("up_floor", 32'(floor), ((i + 1) / 4 > 7) ? 32'd7 : 32'((i + 1) / 4));
      chk("up_arrive", 32'(floor_arrive), (i % 4 == 3 && i < 28) ? 32'd1 : 32'd0);
      chk("up_limit", 32'(limit_hit), (i >= 28) ? 32'd1 : 32'd0);
    end
    chk("up_fault", 32'(fault), 32'd0);

    // Open at the top floor, then try to move with the door open.
    engine = 2'b00; door = 2'b01;
    step();
    chk("open_state", 32'(door_state), 32'd1);
    door = 2'b00;
    step();
    step();
    chk("opening_state", 32'(door_state), 32'd1);
    chk("opening_not_open", 32'(door_open), 32'd0);
    step();
    chk("open_done", 32'(door_open), 32'd1);
    chk("open_done_state", 32'(door_state), 32'd2);
    engine = 2'b01;
    step();
    chk("doorfault_fault", 32'(fault), 32'd1);
    chk("doorfault_floor", 32'(floor), 32'd7);
    chk("doorfault_limit", 32'(limit_hit), 32'd0);
    engine = 2'b00;

    // Close, obstruct on the second closing cycle, reopen, then close cleanly.
    door = 2'b10;
    step();
    chk("close1_state", 32'(door_state), 32'd3);
    door = 2'b00;
    step();
    chk("close2_state", 32'(door_state), 32'd3);
    obstruct = 1'b1;
    step();
    chk("reverse_state", 32'(door_state), 32'd1);
    obstruct = 1'b0;
    step();
    step();
    chk("reopen_state", 32'(door_state), 32'd1);
    step();
    chk("reopen_done", 32'(door_state), 32'd2);
    door = 2'b10;
    step();
    door = 2'b00;
    step();
    step();
    chk("closing_state", 32'(door_state), 32'd3);
    chk("closing_not_closed", 32'(door_closed), 32'd0);
    step();
    chk("closed_state", 32'(door_state), 32'd0);
    chk("closed_flag", 32'(door_closed), 32'd1);

    // Fresh start: bottom limit, climb to floor 3, reversal mid-span, full descent.
    reset = 1'b1;
    #1;
    chk("rst2_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    engine = 2'b10;
    step();
    chk("bottom_limit", 32'(limit_hit), 32'd1);
    chk("bottom_floor", 32'(floor), 32'd0);
    engine = 2'b01;
    for (int i = 0; i < 12; i++) step();
    chk("f3_floor", 32'(floor), 32'd3);
    chk("f3_level", 32'(at_floor), 32'd1);
    engine = 2'b10;
    step();
    chk("dn1_floor", 32'(floor), 32'd2);
    chk("dn1_level", 32'(at_floor), 32'd0);
    chk("dn1_arrive", 32'(floor_arrive), 32'd0);
    step();
    engine = 2'b01;
    step();
    chk("rev1_floor", 32'(floor), 32'd2);
    chk("rev1_arrive", 32'(floor_arrive), 32'd0);
    chk("rev1_level", 32'(at_floor), 32'd0);
    step();
    chk("rev2_floor", 32'(floor), 32'd3);
    chk("rev2_arrive", 32'(floor_arrive), 32'd1);
    chk("rev2_level", 32'(at_floor), 32'd1);
    engine = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dn_arrive", 32'(floor_arrive), (i == 3) ? 32'd1 : 32'd0);
      chk("dn_floor", 32'(floor), 32'd2);
    end
    chk("dn_level", 32'(at_floor), 32'd1);

    // Reset in the middle of a span, then an illegal engine code.
    engine = 2'b01;
    step();
    step();
    engine = 2'b00;
    reset = 1'b1;
    #1;
    chk("midrst_floor", 32'(floor), 32'd0);
    chk("midrst_level", 32'(at_floor), 32'd1);
    chk("midrst_arrive", 32'(floor_arrive), 32'd0);
    chk("midrst_door", 32'(door_state), 32'd0);
    chk("midrst_closed", 32'(door_closed), 32'd1);
    reset = 1'b0;
    engine = 2'b11;
    step();
    chk("illegal_fault", 32'(fault), 32'd1);
    chk("illegal_floor", 32'(floor), 32'd0);
    chk("illegal_level", 32'(at_floor), 32'd1);
    engine = 2'b00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
